// File: rtl/arch_dump_pkg.sv
// Shared types and defaults for the architectural-state dumper: FSM states,
// stream word kinds and the packed word carried through the output buffer.
package arch_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REGS  = 2'd1,
    MEM   = 2'd2,
    DRAIN = 2'd3
  } dump_state_e;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  localparam int          DEF_NUM_REGS  = 32;
  localparam logic [31:0] DEF_MEM_BASE  = 32'h0000_4000;
  localparam int          DEF_MEM_WORDS = 4;

  localparam int WORD_W = 34;

  typedef struct packed {
    logic [31:0] data;
    logic        kind;
    logic        last;
  } dump_word_t;

endpackage

// File: rtl/dump_skid_buffer.sv
// Two-entry valid/ready buffer; slot0 is always the head and drives the output.
// Accepts a push while full if the head leaves in the same cycle.
module dump_skid_buffer #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_q, slot1_q;
  logic [1:0]   count_q;
  logic         push, pop;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count_q != 2'd2) || pop;
  assign push      = in_valid && in_ready;
  assign out_data  = slot0_q;
  assign count     = count_q;

  // NOTE: the storage slots are reset too, because slot0 is the visible stream
  // word and must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= in_data;
          else                 slot1_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_q <= in_data;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arch_state_dumper.sv
// Streams all register-file words, then a window of data-memory words, out as a
// valid/ready word stream once the processor has halted.
module arch_state_dumper
  import arch_dump_pkg::*;
#(
  parameter int          NUM_REGS  = DEF_NUM_REGS,
  parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
  parameter int          MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_kind,
  output logic        out_last
);

  localparam int RCW = $clog2(NUM_REGS + 1);
  localparam int MCW = $clog2(MEM_WORDS + 1);
  localparam logic [RCW-1:0] REG_END  = RCW'(NUM_REGS);
  localparam logic [MCW-1:0] MEM_LAST = MCW'(MEM_WORDS - 1);

  dump_state_e    state_q, state_d;
  logic [RCW-1:0] reg_cnt_q, reg_cnt_d;
  logic [MCW-1:0] mem_cnt_q, mem_cnt_d;
  logic           inflight_q, inflight_last_q;
  logic           done_q, done_d;

  dump_word_t in_word, head_word;
  logic       in_valid, in_ready, buf_valid;
  logic [1:0] buf_count;
  logic       accept, reg_req, push, pop, issue;
  logic [2:0] occ_next;

  assign accept   = (state_q == IDLE) && start && !done_q;
  assign reg_req  = accept || ((state_q == REGS) && (reg_cnt_q != REG_END));
  assign pop      = buf_valid && out_ready;
  assign in_valid = reg_req || inflight_q;
  assign push     = in_valid && in_ready;
  // Occupancy after this edge; a read may issue only if its word will fit.
  assign occ_next = 3'(buf_count) + 3'(push) - 3'(pop);

  assign rf_raddr  = ((state_q == REGS) && (reg_cnt_q != REG_END)) ? 5'(reg_cnt_q) : 5'd0;
  assign mem_ren   = issue;
  assign mem_raddr = issue ? (MEM_BASE + 32'(mem_cnt_q)) : 32'd0;

  // Reads only issue after the last register word is queued, so a returning
  // memory word and a register word never compete for the buffer.
  always_comb begin
    in_word = '0;
    if (inflight_q) begin
      in_word.data = mem_rdata;
      in_word.kind = KIND_MEM;
      in_word.last = inflight_last_q;
    end else begin
      in_word.data = rf_rdata;
      in_word.kind = KIND_REG;
      in_word.last = 1'b0;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    reg_cnt_d = reg_cnt_q;
    mem_cnt_d = mem_cnt_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = REGS;
          reg_cnt_d = RCW'(1);
          mem_cnt_d = '0;
        end
      end
      REGS: begin
        if (push && (reg_cnt_q != REG_END)) reg_cnt_d = reg_cnt_q + RCW'(1);
        if (reg_cnt_d == REG_END) begin
          issue   = (occ_next < 3'd2);
          state_d = MEM;
        end
      end
      MEM:   issue = (occ_next < 3'd2);
      DRAIN: begin
        if (occ_next == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      mem_cnt_d = mem_cnt_q + MCW'(1);
      if (mem_cnt_q == MEM_LAST) state_d = DRAIN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      reg_cnt_q       <= '0;
      mem_cnt_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      reg_cnt_q       <= reg_cnt_d;
      mem_cnt_q       <= mem_cnt_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (mem_cnt_q == MEM_LAST);
      done_q          <= done_d;
    end
  end

  dump_skid_buffer #(.W(WORD_W)) u_buf (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_word),
    .out_valid(buf_valid),
    .out_ready(out_ready),
    .out_data (head_word),
    .count    (buf_count)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = buf_valid;
  assign out_data  = head_word.data;
  assign out_kind  = head_word.kind;
  assign out_last  = head_word.last;

endmodule
